datamem_ctrl: RTL and testbench

Parametrised successor to the single-port 8-bit data memory. Adds configurable width and depth, a valid/ready request handshake, a registered (1-cycle) read response, and a hardware clear engine that zero-fills the whole array one word per cycle. Sits between the core's load/store stage and storage. The core stalls on req_ready=0 instead of assuming fixed single-cycle access.

---
 rtl/datamem_pkg.sv | 13 +
 rtl/datamem_array.sv | 38 +++
 rtl/datamem_ctrl.sv | 100 ++++++++++
 tb/tb_datamem_ctrl.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/datamem_pkg.sv
// rtl/datamem_pkg.sv - shared state type and default sizes for the data memory controller
package datamem_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CLEAR = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam int DATA_W_DEF = 8;
   localparam int ADDR_W_DEF = 8;

endpackage

// File: rtl/datamem_array.sv
// rtl/datamem_array.sv - word storage with one write port and a registered read port
module datamem_array
   import datamem_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] mem [DEPTH];

   // Contents are deliberately left unreset so the array maps onto plain RAM.
   always_ff @(posedge clock) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // Output register holds its last value between reads.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rdata <= '0;
      end else if (re) begin
         rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/datamem_ctrl.sv
// rtl/datamem_ctrl.sv - request handshake, clear sweep FSM and port mux in front of datamem_array
module datamem_ctrl
   import datamem_pkg::*;
#(
   parameter int DATA_W         = DATA_W_DEF,
   parameter int ADDR_W         = ADDR_W_DEF,
   parameter bit CLEAR_ON_RESET = 1'b0
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   input  logic              clear_start,
   output logic              busy,
   output logic              clear_done
);

   state_t            state;
   state_t            state_nxt;
   logic [ADDR_W-1:0] cnt;
   logic              init_pend;
   logic              start;
   logic              accept;
   logic              rd_accept;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_waddr;
   logic [DATA_W-1:0] mem_wdata;

   // init_pend turns the first post-reset cycle into a clear request when enabled.
   assign start     = clear_start | init_pend;
   assign accept    = req_valid & req_ready;
   assign rd_accept = accept & ~req_we;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         cnt       <= '0;
         init_pend <= CLEAR_ON_RESET;
         rsp_valid <= 1'b0;
      end else begin
         state     <= state_nxt;
         init_pend <= 1'b0;
         rsp_valid <= rd_accept;
         if (state == CLEAR) begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   always_comb begin
      state_nxt  = state;
      req_ready  = 1'b0;
      busy       = 1'b0;
      clear_done = 1'b0;
      case (state)
         IDLE: begin
            req_ready = ~start;
            if (start) begin
               state_nxt = CLEAR;
            end
         end
         CLEAR: begin
            busy = 1'b1;
            if (cnt == '1) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            clear_done = 1'b1;
            state_nxt  = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // The sweep owns the write port while clearing; requests cannot be accepted then.
   assign mem_we    = (state == CLEAR) | (accept & req_we);
   assign mem_waddr = (state == CLEAR) ? cnt : req_addr;
   assign mem_wdata = (state == CLEAR) ? '0 : req_wdata;

   datamem_array #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_array (
      .clock   (clock),
      .reset_n (reset_n),
      .we      (mem_we),
      .waddr   (mem_waddr),
      .wdata   (mem_wdata),
      .re      (rd_accept),
      .raddr   (req_addr),
      .rdata   (rsp_rdata)
   );

endmodule

// File: tb/tb_datamem_ctrl.sv
// tb/tb_datamem_ctrl.sv - scoreboard bench for datamem_ctrl in default and 16x16 clear-on-reset builds
module tb_datamem_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [15:0] data;
      int          due;
   } exp_t;

   exp_t qa[$];
   exp_t qb[$];
   exp_t ea;
   exp_t eb;

   logic        a_rst_n, a_valid, a_ready, a_we, a_rsp_valid, a_clear_start, a_busy, a_done;
   logic [7:0]  a_addr, a_wdata, a_rdata;
   logic        b_rst_n, b_valid, b_ready, b_we, b_rsp_valid, b_clear_start, b_busy, b_done;
   logic [3:0]  b_addr;
   logic [15:0] b_wdata, b_rdata;

   datamem_ctrl u_dut_a (
      .clock       (clk),
      .reset_n     (a_rst_n),
      .req_valid   (a_valid),
      .req_ready   (a_ready),
      .req_we      (a_we),
      .req_addr    (a_addr),
      .req_wdata   (a_wdata),
      .rsp_valid   (a_rsp_valid),
      .rsp_rdata   (a_rdata),
      .clear_start (a_clear_start),
      .busy        (a_busy),
      .clear_done  (a_done)
   );

   datamem_ctrl #(
      .DATA_W         (16),
      .ADDR_W         (4),
      .CLEAR_ON_RESET (1'b1)
   ) u_dut_b (
      .clock       (clk),
      .reset_n     (b_rst_n),
      .req_valid   (b_valid),
      .req_ready   (b_ready),
      .req_we      (b_we),
      .req_addr    (b_addr),
      .req_wdata   (b_wdata),
      .rsp_valid   (b_rsp_valid),
      .rsp_rdata   (b_rdata),
      .clear_start (b_clear_start),
      .busy        (b_busy),
      .clear_done  (b_done)
   );

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Response monitors: pop on every rsp_valid and check data and arrival cycle.
   always @(negedge clk) begin
      if (a_rsp_valid) begin
         if (qa.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL a_rsp_unexpected: rsp_valid=1 data %0h, required no response", a_rdata);
         end else begin
            ea = qa.pop_front();
            check("a_rsp_cycle", cyc, ea.due);
            check("a_rsp_data", {24'd0, a_rdata}, {16'd0, ea.data});
         end
      end else if (qa.size() > 0 && qa[0].due <= cyc) begin
         ea = qa.pop_front();
         n_cmp++;
         n_err++;
         $display("FAIL a_rsp_missing: rsp_valid=0 at cycle %0d, required data %0h", cyc, ea.data);
      end
   end

   always @(negedge clk) begin
      if (b_rsp_valid) begin
         if (qb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL b_rsp_unexpected: rsp_valid=1 data %0h, required no response", b_rdata);
         end else begin
            eb = qb.pop_front();
            check("b_rsp_cycle", cyc, eb.due);
            check("b_rsp_data", {16'd0, b_rdata}, {16'd0, eb.data});
         end
      end else if (qb.size() > 0 && qb[0].due <= cyc) begin
         eb = qb.pop_front();
         n_cmp++;
         n_err++;
         $display("FAIL b_rsp_missing: rsp_valid=0 at cycle %0d, required data %0h", cyc, eb.data);
      end
   end

   // All request tasks enter and leave 1 time unit after a rising edge.
   task automatic a_write(input logic [7:0] ad, input logic [7:0] d);
      a_valid = 1'b1; a_we = 1'b1; a_addr = ad; a_wdata = d;
      @(posedge clk); #1;
      a_valid = 1'b0; a_we = 1'b0;
   endtask

   task automatic a_read(input logic [7:0] ad, input logic [7:0] d);
      a_valid = 1'b1; a_we = 1'b0; a_addr = ad;
      qa.push_back('{data: {8'd0, d}, due: cyc + 1});
      @(posedge clk); #1;
      a_valid = 1'b0;
   endtask

   task automatic b_write(input logic [3:0] ad, input logic [15:0] d);
      b_valid = 1'b1; b_we = 1'b1; b_addr = ad; b_wdata = d;
      @(posedge clk); #1;
      b_valid = 1'b0; b_we = 1'b0;
   endtask

   task automatic b_read(input logic [3:0] ad, input logic [15:0] d);
      b_valid = 1'b1; b_we = 1'b0; b_addr = ad;
      qb.push_back('{data: d, due: cyc + 1});
      @(posedge clk); #1;
      b_valid = 1'b0;
   endtask

   task automatic a_fill(input logic [7:0] d);
      for (int i = 0; i < 256; i++) a_write(8'(i), d);
   endtask

   task automatic a_sweep(input bit with_write, input bit restart, input int abort_at);
      int n;
      int rdy_bad;
      a_clear_start = 1'b1;
      if (with_write) begin
         a_valid = 1'b1; a_we = 1'b1; a_addr = 8'h05; a_wdata = 8'h77;
      end
      @(negedge clk);
      if (with_write) check("a_ready_clear_wins", {31'd0, a_ready}, 32'd0);
      @(posedge clk); #1;
      a_clear_start = 1'b0; a_valid = 1'b0; a_we = 1'b0;
      n = 0;
      rdy_bad = 0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (!a_busy) break;
         n++;
         if (a_ready) rdy_bad++;
         if (restart && n == 50) a_clear_start = 1'b1;
         if (restart && n == 51) a_clear_start = 1'b0;
         if (n == abort_at) begin
            a_rst_n = 1'b0;
            #1;
            check("a_abort_busy", {31'd0, a_busy}, 32'd0);
            check("a_abort_rsp_valid", {31'd0, a_rsp_valid}, 32'd0);
            check("a_abort_rdata", {24'd0, a_rdata}, 32'd0);
            check("a_abort_ready", {31'd0, a_ready}, 32'd1);
            @(posedge clk); #1;
            a_rst_n = 1'b1;
            return;
         end
      end
      check("a_busy_cycles", n, 256);
      check("a_ready_low_in_clear", rdy_bad, 0);
      check("a_done_pulse", {31'd0, a_done}, 32'd1);
      check("a_ready_low_in_done", {31'd0, a_ready}, 32'd0);
      @(negedge clk);
      check("a_done_single", {31'd0, a_done}, 32'd0);
      check("a_ready_after_done", {31'd0, a_ready}, 32'd1);
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, required completion");
      $fatal(1, "timeout");
   end

   initial begin
      int nb;
      a_rst_n = 1'b0; a_valid = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0; a_clear_start = 1'b0;
      b_rst_n = 1'b0; b_valid = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0; b_clear_start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("a_rst_busy", {31'd0, a_busy}, 32'd0);
      check("a_rst_done", {31'd0, a_done}, 32'd0);
      check("a_rst_rsp_valid", {31'd0, a_rsp_valid}, 32'd0);
      check("a_rst_rdata", {24'd0, a_rdata}, 32'd0);
      check("a_rst_ready", {31'd0, a_ready}, 32'd1);
      check("b_rst_busy", {31'd0, b_busy}, 32'd0);
      check("b_rst_done", {31'd0, b_done}, 32'd0);
      a_rst_n = 1'b1;
      @(posedge clk); #1;

      a_write(8'h10, 8'h5A);
      a_read(8'h10, 8'h5A);
      a_write(8'h01, 8'h11);
      a_write(8'h02, 8'h22);
      a_write(8'h03, 8'h33);
      a_read(8'h01, 8'h11);
      a_read(8'h02, 8'h22);
      a_read(8'h03, 8'h33);
      @(posedge clk); #1;
      @(negedge clk);
      check("a_rsp_drop", {31'd0, a_rsp_valid}, 32'd0);
      check("a_rdata_hold", {24'd0, a_rdata}, 32'h33);
      @(posedge clk); #1;

      a_fill(8'hFF);
      a_sweep(1'b0, 1'b0, 0);
      a_read(8'h00, 8'h00);
      a_read(8'h80, 8'h00);
      a_read(8'hFF, 8'h00);

      a_sweep(1'b1, 1'b1, 0);
      a_read(8'h05, 8'h00);

      a_fill(8'hFF);
      a_read(8'h10, 8'hFF);
      @(posedge clk); #1;
      a_sweep(1'b0, 1'b0, 100);
      a_read(8'h00, 8'h00);
      a_read(8'h31, 8'h00);
      a_read(8'h62, 8'h00);
      a_read(8'hC8, 8'hFF);
      a_read(8'hFF, 8'hFF);

      b_rst_n = 1'b1;
      nb = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (b_busy) nb++;
         else if (nb > 0) break;
      end
      check("b_busy_cycles", nb, 16);
      check("b_done_pulse", {31'd0, b_done}, 32'd1);
      @(posedge clk); #1;
      b_write(4'hF, 16'hBEEF);
      b_read(4'hF, 16'hBEEF);
      b_read(4'h3, 16'h0000);

      repeat (3) @(posedge clk);
      #1;
      check("a_queue_drained", qa.size(), 0);
      check("b_queue_drained", qb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
